// File: rtl/alu_fwd_sel.sv
// Operand-forwarding select for a two-deep EX result history, with load-use stall detection.
// Define FWD_STAGE2_EN to enable the older (stage-2) forwarding entry; otherwise only stage 1 forwards.
module alu_fwd_sel (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic [2:0]  res_reg,
    input  logic [15:0] res_data,
    input  logic        res_is_ld,
    input  logic        hold,
    input  logic        flush,
    input  logic [2:0]  srcA_reg,
    input  logic [2:0]  srcB_reg,
    input  logic        srcA_use,
    input  logic        srcB_use,
    input  logic [2:0]  imm_selB,
    output logic [1:0]  selA,
    output logic [2:0]  selB,
    output logic [15:0] fwd1_data,
    output logic [15:0] fwd2_data,
    output logic        ld_stall
);

    logic        h1_vld_q, h1_vld_d;
    logic [2:0]  h1_reg_q, h1_reg_d;
    logic [15:0] h1_data_q, h1_data_d;
    logic        h1_ld_q, h1_ld_d;

    logic h1_hit_a, h1_hit_b, h2_hit_a, h2_hit_b;
    logic stall_a, stall_b;

    // Stage 1: newest result; flush squashes it even while the pipe is held
    always_comb begin
        h1_vld_d  = h1_vld_q;
        h1_reg_d  = h1_reg_q;
        h1_data_d = h1_data_q;
        h1_ld_d   = h1_ld_q;
        if (!hold) begin
            h1_vld_d  = res_valid;
            h1_reg_d  = res_reg;
            h1_data_d = res_data;
            h1_ld_d   = res_is_ld;
        end
        if (flush) begin
            h1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h1_vld_q  <= 1'b0;
            h1_reg_q  <= 3'd0;
            h1_data_q <= 16'h0000;
            h1_ld_q   <= 1'b0;
        end else begin
            h1_vld_q  <= h1_vld_d;
            h1_reg_q  <= h1_reg_d;
            h1_data_q <= h1_data_d;
            h1_ld_q   <= h1_ld_d;
        end
    end

    assign fwd1_data = h1_data_q;

`ifdef FWD_STAGE2_EN
    logic        h2_vld_q, h2_vld_d;
    logic [2:0]  h2_reg_q, h2_reg_d;
    logic [15:0] h2_data_q, h2_data_d;

    // Stage 2: a load in stage 1 picks up its returned data as it shifts down
    always_comb begin
        h2_vld_d  = h2_vld_q;
        h2_reg_d  = h2_reg_q;
        h2_data_d = h2_data_q;
        if (!hold) begin
            h2_vld_d  = h1_vld_q;
            h2_reg_d  = h1_reg_q;
            h2_data_d = h1_ld_q ? res_data : h1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h2_vld_q  <= 1'b0;
            h2_reg_q  <= 3'd0;
            h2_data_q <= 16'h0000;
        end else begin
            h2_vld_q  <= h2_vld_d;
            h2_reg_q  <= h2_reg_d;
            h2_data_q <= h2_data_d;
        end
    end

    assign h2_hit_a  = h2_vld_q && (h2_reg_q == srcA_reg) && srcA_use;
    assign h2_hit_b  = h2_vld_q && (h2_reg_q == srcB_reg) && srcB_use;
    assign fwd2_data = h2_data_q;
`else
    assign h2_hit_a  = 1'b0;
    assign h2_hit_b  = 1'b0;
    assign fwd2_data = 16'h0000;
`endif

    assign h1_hit_a = h1_vld_q && (h1_reg_q == srcA_reg) && srcA_use;
    assign h1_hit_b = h1_vld_q && (h1_reg_q == srcB_reg) && srcB_use;

    // Immediate B operands never need the loaded value, so they cannot stall
    assign stall_a  = h1_hit_a && h1_ld_q;
    assign stall_b  = h1_hit_b && h1_ld_q && (imm_selB == 3'b000);
    assign ld_stall = stall_a || stall_b;

    always_comb begin
        selA = 2'b00;
        if (stall_a) begin
            selA = 2'b00;
        end else if (h1_hit_a) begin
            selA = 2'b01;
        end else if (h2_hit_a) begin
            selA = 2'b10;
        end
    end

    always_comb begin
        selB = 3'b000;
        if (imm_selB != 3'b000) begin
            selB = imm_selB;
        end else if (stall_b) begin
            selB = 3'b000;
        end else if (h1_hit_b) begin
            selB = 3'b001;
        end else if (h2_hit_b) begin
            selB = 3'b010;
        end
    end

endmodule

// File: tb/tb_alu_fwd_sel.sv
// Scoreboard bench for alu_fwd_sel: directed cycles push expected outputs, a negedge monitor compares.
module tb_alu_fwd_sel;

`ifdef FWD_STAGE2_EN
    localparam bit S2 = 1'b1;
`else
    localparam bit S2 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [2:0]  res_reg;
    logic [15:0] res_data;
    logic        res_is_ld;
    logic        hold;
    logic        flush;
    logic [2:0]  srcA_reg, srcB_reg;
    logic        srcA_use, srcB_use;
    logic [2:0]  imm_selB;
    logic [1:0]  selA;
    logic [2:0]  selB;
    logic [15:0] fwd1_data, fwd2_data;
    logic        ld_stall;

    alu_fwd_sel dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_reg(res_reg), .res_data(res_data), .res_is_ld(res_is_ld),
        .hold(hold), .flush(flush),
        .srcA_reg(srcA_reg), .srcB_reg(srcB_reg), .srcA_use(srcA_use), .srcB_use(srcB_use),
        .imm_selB(imm_selB),
        .selA(selA), .selB(selB), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .ld_stall(ld_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sa;
        logic [2:0]  sb;
        logic        st;
        logic [15:0] f1;
        logic [15:0] f2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: outputs are combinational/registered and valid every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".selA"},     {14'd0, selA},     {14'd0, e.sa});
            chk({e.name, ".selB"},     {13'd0, selB},     {13'd0, e.sb});
            chk({e.name, ".ld_stall"}, {15'd0, ld_stall}, {15'd0, e.st});
            chk({e.name, ".fwd1"},     fwd1_data,         e.f1);
            chk({e.name, ".fwd2"},     fwd2_data,         e.f2);
        end
    end

    task automatic apply(input logic rv, input logic [2:0] rr, input logic [15:0] rd, input logic rl,
                         input logic hl, input logic fl,
                         input logic [2:0] ar, input logic au, input logic [2:0] br, input logic bu,
                         input logic [2:0] imm, input logic rs);
        res_valid = rv; res_reg = rr; res_data = rd; res_is_ld = rl;
        hold = hl; flush = fl;
        srcA_reg = ar; srcA_use = au; srcB_reg = br; srcB_use = bu;
        imm_selB = imm; rst = rs;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] sa, input logic [2:0] sb,
                              input logic st, input logic [15:0] f1, input logic [15:0] f2);
        exp_t e;
        e.name = nm; e.sa = sa; e.sb = sb; e.st = st; e.f1 = f1; e.f2 = f2;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        apply(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
        tick(); tick();

        // write R3 = 1234 while checking the post-reset state
        apply(1, 3, 16'h1234, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0);
        expect_out("reset", 2'b00, 3'b000, 0, 16'h0000, 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 0, 0, 7, 1, 3, 1, 3'b000, 0);
        expect_out("h1_fwd_b", 2'b00, 3'b001, 0, 16'h1234, 16'h0000);
        tick();
        apply(1, 2, 16'hAAAA, 0, 0, 0, 3, 0, 3, 1, 3'b000, 0);
        expect_out("h2_fwd_b", 2'b00, S2 ? 3'b010 : 3'b000, 0, 16'h0000, S2 ? 16'h1234 : 16'h0000);
        tick();
        apply(1, 2, 16'hBBBB, 0, 0, 0, 2, 1, 2, 1, 3'b011, 0);
        expect_out("imm_over_hit", 2'b01, 3'b011, 0, 16'hAAAA, 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 0, 0, 2, 1, 2, 1, 3'b000, 0);
        expect_out("newest_wins", 2'b01, 3'b001, 0, 16'hBBBB, S2 ? 16'hAAAA : 16'h0000);
        tick();
        // load to R5; older R2 still visible in stage 2
        apply(1, 5, 16'hDEAD, 1, 0, 0, 2, 1, 0, 0, 3'b000, 0);
        expect_out("h2_only_a", S2 ? 2'b10 : 2'b00, 3'b000, 0, 16'h0000, S2 ? 16'hBBBB : 16'h0000);
        tick();
        apply(0, 0, 16'h00FF, 0, 0, 0, 5, 1, 5, 1, 3'b100, 0);
        expect_out("ld_use_a", 2'b00, 3'b100, 1, 16'hDEAD, 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 0, 0, 5, 1, 5, 1, 3'b000, 0);
        expect_out("ld_resolved", S2 ? 2'b10 : 2'b00, S2 ? 3'b010 : 3'b000, 0, 16'h00FF,
                   S2 ? 16'h00FF : 16'h0000);
        tick();
        // load to R4, then B-side use with immediate and with register path
        apply(1, 4, 16'h1111, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        expect_out("idle", 2'b00, 3'b000, 0, 16'h0000, S2 ? 16'h00FF : 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 1, 0, 0, 0, 4, 1, 3'b100, 0);
        expect_out("ld_imm_b", 2'b00, 3'b100, 0, 16'h1111, 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 1, 0, 0, 0, 4, 1, 3'b000, 0);
        expect_out("ld_use_b", 2'b00, 3'b000, 1, 16'h1111, 16'h0000);
        tick();
        // R6 = 6666 enters stage 1; the R4 load takes res_data 6666 into stage 2
        apply(1, 6, 16'h6666, 0, 0, 0, 6, 1, 0, 0, 3'b000, 0);
        expect_out("ld_shift", 2'b00, 3'b000, 0, 16'h1111, 16'h0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 16'h9999, 0, 1, 0, 6, 1, 4, 1, 3'b000, 0);
            expect_out("hold", 2'b01, S2 ? 3'b010 : 3'b000, 0, 16'h6666, S2 ? 16'h6666 : 16'h0000);
            tick();
        end
        apply(1, 1, 16'h9999, 0, 1, 1, 6, 1, 4, 1, 3'b000, 0);
        expect_out("hold_flush", 2'b01, S2 ? 3'b010 : 3'b000, 0, 16'h6666, S2 ? 16'h6666 : 16'h0000);
        tick();
        apply(1, 1, 16'h9999, 0, 1, 0, 6, 1, 4, 1, 3'b000, 0);
        expect_out("after_flush", 2'b00, S2 ? 3'b010 : 3'b000, 0, 16'h6666, S2 ? 16'h6666 : 16'h0000);
        tick();
        // R0 forwards like any other register
        apply(1, 0, 16'h0ABC, 0, 0, 0, 6, 1, 4, 1, 3'b000, 0);
        expect_out("pre_r0", 2'b00, S2 ? 3'b010 : 3'b000, 0, 16'h6666, S2 ? 16'h6666 : 16'h0000);
        tick();
        apply(1, 7, 16'h7777, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0);
        expect_out("r0_fwd", 2'b01, 3'b001, 0, 16'h0ABC, S2 ? 16'h6666 : 16'h0000);
        tick();
        // reset with live history, asserted alongside hold and flush
        apply(0, 0, 16'h0000, 0, 1, 1, 7, 1, 0, 1, 3'b000, 1);
        expect_out("pre_rst", 2'b01, S2 ? 3'b010 : 3'b000, 0, 16'h7777, S2 ? 16'h0ABC : 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 0, 0, 7, 1, 0, 1, 3'b000, 0);
        expect_out("post_rst", 2'b00, 3'b000, 0, 16'h0000, 16'h0000);
        tick();
        apply(0, 0, 16'h0000, 0, 0, 0, 7, 1, 0, 1, 3'b011, 0);
        expect_out("post_rst_imm", 2'b00, 3'b011, 0, 16'h0000, 16'h0000);
        tick();

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/alu_fwd_sel.md
ALU_FWD_SEL -- requirements
Module: alu_fwd_sel

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 res_valid  input  1  EX stage produced a register-writing result this cycle.
REQ-004 res_reg  input  3  destination register of EX result.
REQ-005 res_data  input  16  EX result value; don't-care for loads.
REQ-006 res_is_ld  input  1  EX instruction is a load; its data is not yet available.
REQ-007 hold  input  1  pipeline stall; history frozen.
REQ-008 flush  input  1  squash the newest history entry (branch mispredict).
REQ-009 srcA_reg, srcB_reg  input  3 each  source registers of the instruction in decode.
REQ-010 srcA_use, srcB_use  input  1 each  operand actually read.
REQ-011 imm_selB  input  3  decoder B-operand choice; 000 = register path, 011/100 = immediate forms.
REQ-012 selA  output  2  A-operand select: 00 regfile, 01 stage-1 result, 10 stage-2 result.
REQ-013 selB  output  3  B-operand mux select code, same 3-bit encoding as the B mux (000 regfile, 001 stage-1, 010 stage-2, 011/100 immediates, 101-111 zero).
REQ-014 fwd1_data, fwd2_data  output  16 each  registered stage-1 / stage-2 result values.
REQ-015 ld_stall  output  1  load-use hazard; decode stage must hold.

Function
REQ-016 Block SHALL keep a 2-entry history: H1 (newest: valid, reg, data, is_ld), H2 (older: valid, reg, data).
REQ-017 On a clock edge with hold=0, H2 SHALL take H1 and H1 SHALL take {res_valid, res_reg, res_data, res_is_ld}.
REQ-018 On a clock edge with hold=1, H1 and H2 SHALL keep their values.
REQ-019 flush=1 SHALL clear H1.valid on that edge, with priority over both hold and the new capture; H2 is updated per REQ-017/018.
REQ-020 When H1.is_ld=1 and H1 shifts into H2, H2.data SHALL take res_data of that cycle (load data returned one stage later).
REQ-021 selA/selB SHALL be combinational from current history and source inputs (zero-cycle decode latency).
REQ-022 Match rule: Hn hits for a source when Hn.valid=1 and Hn.reg equals the source register and the source use bit=1.
REQ-023 Priority SHALL be H1 hit over H2 hit over regfile; on a double hit, the newest (H1) SHALL win.
REQ-024 If imm_selB is not 000, selB SHALL equal imm_selB regardless of hits; otherwise selB SHALL follow REQ-023.
REQ-025 ld_stall SHALL be 1 when H1.valid=1, H1.is_ld=1 and H1 hits srcA, or H1 hits srcB with imm_selB=000; selA/selB SHALL then read 00/000 for the stalled source.
REQ-026 fwd1_data SHALL equal H1.data; fwd2_data SHALL equal H2.data.
REQ-027 No register is special; a write to R0 is forwarded like any other register.

Reset
REQ-028 rst=1 on a clock edge SHALL clear H1/H2 valid, reg, data and is_ld to 0; rst overrides hold and flush.
REQ-029 After reset: selA=00, selB=imm_selB (000 with no immediate), ld_stall=0, fwd1_data=fwd2_data=16'h0000.
REQ-030 Reset mid-operation SHALL discard all pending history; there is no forwarding until new results are captured.

Configuration
REQ-031 Macro FWD_STAGE2_EN defined: full 2-entry behaviour as above.
REQ-032 FWD_STAGE2_EN undefined: H2 SHALL be absent, fwd2_data SHALL be tied to 16'h0000, codes 10/010 SHALL never be generated, and a hit only in the older stage SHALL fall back to regfile.

Verification
REQ-033 Reset, then res_valid=1 reg=3 data=16'h1234; next cycle srcB_reg=3, use=1, imm_selB=000 -> selB=001, fwd1_data=16'h1234.
REQ-034 Write R2=16'hAAAA, then R2=16'hBBBB; read srcA=2 -> selA=01, fwd1_data=16'hBBBB (newest wins); with FWD_STAGE2_EN, fwd2_data=16'hAAAA.
REQ-035 Load to R5 (res_is_ld=1); next cycle srcA=5 -> ld_stall=1, selA=00; after one non-hold edge with res_data=16'h00FF -> ld_stall=0, selA=10, fwd2_data=16'h00FF.
REQ-036 H1 hit on srcB with imm_selB=100 -> selB=100, ld_stall=0 even if H1 is a load.
REQ-037 hold=1 for 3 cycles with new res_* values -> fwd1/fwd2 unchanged; flush=1 with hold=1 -> H1.valid cleared, selA=00.
REQ-038 rst=1 asserted with a valid H1 entry -> the next cycle shows selA=00, selB=000, ld_stall=0 and both fwd data outputs 16'h0000.
